// File: rtl/cpu_step_ctrl_pkg.sv
// rtl/cpu_step_ctrl_pkg.sv - run-control state encodings and address width for cpu_step_ctrl
package cpu_step_ctrl_pkg;

   localparam int INST_ADDR_W = 32;

   typedef enum logic [1:0] {
      STEP_HALT = 2'd0,
      STEP_RUN  = 2'd1,
      STEP_STEP = 2'd2,
      STEP_BRK  = 2'd3
   } step_state_e;

   // The display path treats a breakpoint stop the same as a manual halt.
   function automatic logic state_halted(input step_state_e s);
      return (s == STEP_HALT) || (s == STEP_BRK);
   endfunction

endpackage

// File: rtl/cpu_step_ctrl_slow_tick_gen.sv
// rtl/cpu_step_ctrl_slow_tick_gen.sv - DIV_W-bit divider producing the slow-run enable tick
module cpu_step_ctrl_slow_tick_gen #(
   parameter int DIV_W = 24
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   input  logic slow_sel,
   output logic tick
);

   logic [DIV_W-1:0] div;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div <= '0;
      end else if (clr) begin
         div <= '0;
      end else if (en) begin
         div <= div + DIV_W'(1);
      end
   end

   assign tick = slow_sel ? (&div) : 1'b1;

endmodule

// File: rtl/cpu_step_ctrl.sv
// rtl/cpu_step_ctrl.sv - CPU run/step/breakpoint clock-enable control
// Executed-cycle counter is built only when CPU_STEP_CYCLE_CNT_EN is defined.
module cpu_step_ctrl
   import cpu_step_ctrl_pkg::*;
#(
   parameter int DIV_W = 24,
   parameter int CNT_W = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   run_pulse_i,
   input  logic                   step_pulse_i,
   input  logic                   slow_sel_i,
   input  logic                   bp_en_i,
   input  logic [INST_ADDR_W-1:0] bp_addr_i,
   input  logic [INST_ADDR_W-1:0] pc_i,
   output logic                   cpu_ce_o,
   output logic                   halted_o,
   output logic                   bp_hit_o,
   output logic [CNT_W-1:0]       cycle_cnt_o
);

   step_state_e state;
   logic        skip;
   logic        tick;
   logic        bp_match;
   logic        enter_run;

   // skip masks the breakpoint until the instruction we stopped on has executed.
   assign bp_match  = bp_en_i & (pc_i == bp_addr_i) & ~skip;
   assign cpu_ce_o  = (state == STEP_STEP) | ((state == STEP_RUN) & tick & ~bp_match);
   assign halted_o  = state_halted(state);
   assign enter_run = run_pulse_i & ((state == STEP_HALT) | (state == STEP_BRK));

   cpu_step_ctrl_slow_tick_gen #(
      .DIV_W (DIV_W)
   ) u_slow_tick_gen (
      .clk      (clk),
      .rst      (rst),
      .clr      (enter_run),
      .en       (state == STEP_RUN),
      .slow_sel (slow_sel_i),
      .tick     (tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= STEP_HALT;
         skip     <= 1'b0;
         bp_hit_o <= 1'b0;
      end else begin
         if (cpu_ce_o) begin
            skip <= 1'b0;
         end
         case (state)
            STEP_HALT: begin
               if (run_pulse_i) begin
                  state <= STEP_RUN;
               end else if (step_pulse_i) begin
                  state <= STEP_STEP;
               end
            end
            STEP_STEP: begin
               state <= STEP_HALT;
            end
            STEP_RUN: begin
               if (run_pulse_i) begin
                  state <= STEP_HALT;
               end else if (bp_match) begin
                  state    <= STEP_BRK;
                  bp_hit_o <= 1'b1;
               end
            end
            STEP_BRK: begin
               if (run_pulse_i) begin
                  state    <= STEP_RUN;
                  skip     <= 1'b1;
                  bp_hit_o <= 1'b0;
               end else if (step_pulse_i) begin
                  state    <= STEP_STEP;
                  bp_hit_o <= 1'b0;
               end
            end
            default: begin
               state <= STEP_HALT;
            end
         endcase
      end
   end

`ifdef CPU_STEP_CYCLE_CNT_EN
   logic [CNT_W-1:0] cycle_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_cnt <= '0;
      end else if (cpu_ce_o) begin
         cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
   end

   assign cycle_cnt_o = cycle_cnt;
`else
   assign cycle_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb/tb_cpu_step_ctrl.sv - directed scoreboard bench for cpu_step_ctrl (DIV_W=4)
module tb_cpu_step_ctrl;

   localparam int DIV_W = 4;
   localparam int CNT_W = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic             run_pulse_i;
   logic             step_pulse_i;
   logic             slow_sel_i;
   logic             bp_en_i;
   logic [31:0]      bp_addr_i;
   logic [31:0]      pc_i;
   logic             cpu_ce_o;
   logic             halted_o;
   logic             bp_hit_o;
   logic [CNT_W-1:0] cycle_cnt_o;

   typedef struct {
      logic             ce;
      logic             halted;
      logic             hit;
      logic [CNT_W-1:0] cnt;
      string            tag;
   } exp_t;

   exp_t             sb[$];
   int               passed = 0;
   int               failed = 0;
   int               total  = 0;
   logic [CNT_W-1:0] model_cnt;

   always #5 clk = ~clk;

   cpu_step_ctrl #(
      .DIV_W (DIV_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .run_pulse_i  (run_pulse_i),
      .step_pulse_i (step_pulse_i),
      .slow_sel_i   (slow_sel_i),
      .bp_en_i      (bp_en_i),
      .bp_addr_i    (bp_addr_i),
      .pc_i         (pc_i),
      .cpu_ce_o     (cpu_ce_o),
      .halted_o     (halted_o),
      .bp_hit_o     (bp_hit_o),
      .cycle_cnt_o  (cycle_cnt_o)
   );

   function automatic logic [CNT_W-1:0] cnt_exp();
`ifdef CPU_STEP_CYCLE_CNT_EN
      return model_cnt;
`else
      return '0;
`endif
   endfunction

   task automatic push_exp(input logic ce, input logic h, input logic hit, input string tag);
      exp_t e;
      e.ce     = ce;
      e.halted = h;
      e.hit    = hit;
      e.cnt    = cnt_exp();
      e.tag    = tag;
      sb.push_back(e);
   endtask

   task automatic check_out();
      exp_t e;
      total = total + 1;
      assert (sb.size() != 0) passed++;
      else begin
         failed++;
         $error("FAIL sb_empty got size %0d want nonzero", sb.size());
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         total = total + 4;
         assert (cpu_ce_o === e.ce) passed++;
         else begin
            failed++;
            $error("FAIL %s cpu_ce_o got %b want %b", e.tag, cpu_ce_o, e.ce);
         end
         assert (halted_o === e.halted) passed++;
         else begin
            failed++;
            $error("FAIL %s halted_o got %b want %b", e.tag, halted_o, e.halted);
         end
         assert (bp_hit_o === e.hit) passed++;
         else begin
            failed++;
            $error("FAIL %s bp_hit_o got %b want %b", e.tag, bp_hit_o, e.hit);
         end
         assert (cycle_cnt_o === e.cnt) passed++;
         else begin
            failed++;
            $error("FAIL %s cycle_cnt_o got %0d want %0d", e.tag, cycle_cnt_o, e.cnt);
         end
      end
   endtask

   // One board cycle: drive pulses, check outputs, then let the modelled core fetch on ce.
   task automatic cyc(input logic run, input logic stp, input logic ce, input logic h,
                      input logic hit, input string tag);
      logic ce_seen;
      run_pulse_i  = run;
      step_pulse_i = stp;
      push_exp(ce, h, hit, tag);
      #1;
      check_out();
      ce_seen = cpu_ce_o;
      if (ce) model_cnt = model_cnt + 1;
      @(posedge clk);
      #1;
      run_pulse_i  = 1'b0;
      step_pulse_i = 1'b0;
      if (ce_seen) pc_i = pc_i + 32'd4;
   endtask

   task automatic do_reset(input string tag);
      rst       = 1'b1;
      model_cnt = '0;
      pc_i      = 32'h0;
      push_exp(1'b0, 1'b1, 1'b0, tag);
      #1;
      check_out();
      rst = 1'b0;
   endtask

   initial begin
      run_pulse_i  = 1'b0;
      step_pulse_i = 1'b0;
      slow_sel_i   = 1'b0;
      bp_en_i      = 1'b0;
      bp_addr_i    = 32'h0;
      pc_i         = 32'h0;
      model_cnt    = '0;

      do_reset("reset_state");
      @(posedge clk);
      #1;

      // Single step at cycle 5; a run pulse landing in STEP must be ignored.
      for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "halt_idle");
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "step_req");
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "step_ce");
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "step_done");
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "step_hold");

      // Full-speed run for cycles 1..10.
      do_reset("reset_fast");
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "fast_start");
      for (int k = 1; k <= 10; k++) cyc(k == 10, 1'b0, 1'b1, 1'b0, 1'b0, "fast_run");
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "fast_stop");
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "fast_hold");

      // Slow run: enables at cycles 16 and 32 only.
      do_reset("reset_slow");
      slow_sel_i = 1'b1;
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "slow_start");
      for (int k = 1; k <= 40; k++) cyc(1'b0, 1'b0, (k == 16) || (k == 32), 1'b0, 1'b0, "slow_run");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "slow_cnt");
      slow_sel_i = 1'b0;

      // Breakpoint at 0x10, resume with skip, then breakpoint at 0x20 left by step.
      do_reset("reset_bp");
      bp_en_i   = 1'b1;
      bp_addr_i = 32'h10;
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "bp_start");
      for (int k = 1; k <= 4; k++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "bp_run");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "bp_match");
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "bp_brk");
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "bp_brk_run");
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "bp_skip");
      bp_addr_i = 32'h20;
      for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "bp_resume");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "bp2_match");
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "bp2_brk_step");
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "bp2_step_ce");
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "bp2_halt");
      bp_en_i = 1'b0;

      // Run and step together: run wins; step in RUN is ignored.
      do_reset("reset_both");
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "both_pulse");
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "both_run");
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "run_step_ign");
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "both_run2");
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "both_run3");

      // Asynchronous reset pulse mid-run, checked before the next edge.
      do_reset("mid_run_reset");
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "post_reset_halt");

      total = total + 1;
      assert (sb.size() == 0) passed++;
      else begin
         failed++;
         $error("FAIL sb_leftover got %0d want 0", sb.size());
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
